// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM states and latency lookup shared by the MDU files
package mdu_pkg;
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} mdu_state_e;
  function automatic logic is_md(input logic [2:0] op);
    return !op[2];
  endfunction
  function automatic int lat_of(input logic [2:0] op, input int mul_lat, input int div_lat);
    return op[1] ? div_lat : mul_lat;
  endfunction
endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational mult/div datapath
//   op, a, b      -> operation and operands
//   res_hi/res_lo -> 2*WIDTH result (remainder/quotient for divides)
//   div0          -> divide op with zero divisor
module mdu_calc
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div0
);
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   bs, q_s, r_s, q_u, r_u;
  logic               ovf;
  // Low 2W bits of the product of sign-extended operands equal the signed product.
  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign div0   = op[1] && !op[2] && b == '0;
  assign ovf    = a == {1'b1, {(WIDTH-1){1'b0}}} && &b;
  // Substituting divisor 1 keeps zero-divide and MIN/-1 well defined; MIN/1 gives MIN rem 0.
  assign bs     = (b == '0 || ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
  assign q_s    = $signed(a) / $signed(bs);
  assign r_s    = $signed(a) % $signed(bs);
  assign q_u    = a / bs;
  assign r_u    = a % bs;
  always_comb begin
    res_hi = op == OP_MULT  ? prod_s[2*WIDTH-1:WIDTH] :
             op == OP_MULTU ? prod_u[2*WIDTH-1:WIDTH] :
             op == OP_DIV   ? r_s : r_u;
    res_lo = op == OP_MULT  ? prod_s[WIDTH-1:0] :
             op == OP_MULTU ? prod_u[WIDTH-1:0] :
             op == OP_DIV   ? q_s : q_u;
  end
endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with HI/LO registers
//   start/op/a/b -> issue; cancel -> flush in-flight op or drop issue
//   busy         -> op in flight; done -> one-cycle pulse after commit
//   hi/lo        -> architectural HI/LO registers
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int MAX_LAT = MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT;
  localparam int CW = $clog2(MAX_LAT + 1);
  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] p_hi, p_lo, res_hi, res_lo;
  logic             div0, accept, launch, commit;
  mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .op    (op),
    .a     (a),
    .b     (b),
    .res_hi(res_hi),
    .res_lo(res_lo),
    .div0  (div0)
  );
  assign accept = state_q == IDLE && start && !cancel;
  assign launch = accept && is_md(op);
  assign commit = state_q == RUN && !cancel && cnt == CW'(1);
  assign busy   = state_q == RUN;
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE ? (launch ? RUN : IDLE) : ((cancel || cnt == CW'(1)) ? IDLE : RUN);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      p_hi <= '0;
      p_lo <= '0;
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= commit;
      if (launch) begin
        // A zero divisor captures the current HI/LO so the commit leaves them unchanged.
        p_hi <= div0 ? hi : res_hi;
        p_lo <= div0 ? lo : res_lo;
        cnt  <= CW'(lat_of(op, MUL_LAT, DIV_LAT));
      end else if (state_q == RUN) begin
        cnt <= (cancel || commit) ? '0 : cnt - CW'(1);
      end
      if (commit) begin
        hi <= p_hi;
        lo <= p_lo;
      end else if (accept && op == OP_MTHI) begin
        hi <= a;
      end else if (accept && op == OP_MTLO) begin
        lo <= a;
      end
    end
  end
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed self-checking bench for mdu_unit
module tb_mdu_unit;
  import mdu_pkg::*;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cancel = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;
  int          checks = 0;
  int          errors = 0;
  mdu_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
  endtask
  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y, input int lat);
    int n;
    issue(o, x, y);
    wait_idle(n);
    chk({tag, "_busy_len"}, n, lat);
    chk({tag, "_done"}, done, 1);
  endtask
  initial begin
    int n;
    bit seen;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    reset_n = 1'b1;
    tick();
    run("mult", OP_MULT, 32'hFFFF_FFFD, 32'd7, 5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);
    tick();
    chk("mult_done_pulse", done, 0);
    run("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    run("divu", OP_DIVU, 32'd7, 32'd2, 10);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);
    tick();
    issue(OP_MTHI, 32'h1234, 32'd0);
    chk("mthi_busy", busy, 0);
    chk("mthi_hi", hi, 32'h1234);
    issue(OP_MTLO, 32'h5678, 32'd0);
    chk("mtlo_lo", lo, 32'h5678);
    chk("mtlo_done", done, 0);
    run("div0", OP_DIVU, 32'd7, 32'd0, 10);
    chk("div0_hi", hi, 32'h1234);
    chk("div0_lo", lo, 32'h5678);
    tick();
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    tick();
    tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel3_busy", busy, 0);
    chk("cancel3_done", done, 0);
    chk("cancel3_hi", hi, 32'h1234);
    chk("cancel3_lo", lo, 32'h5678);
    tick();
    chk("cancel3_done_later", done, 0);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    repeat (4) tick();
    chk("cancelF_busy_before", busy, 1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancelF_busy", busy, 0);
    chk("cancelF_done", done, 0);
    chk("cancelF_hi", hi, 32'h1234);
    chk("cancelF_lo", lo, 32'h5678);
    tick();
    chk("cancelF_done_later", done, 0);
    op = OP_MTHI;
    a = 32'hBAD0;
    start = 1'b1;
    cancel = 1'b1;
    tick();
    start = 1'b0;
    cancel = 1'b0;
    chk("cancel_idle_drop", hi, 32'h1234);
    issue(OP_MULT, 32'd2, 32'd3);
    tick();
    op = OP_MTLO;
    a = 32'hDEAD;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(n);
    chk("ignore_busy_len", n, 3);
    chk("ignore_done", done, 1);
    chk("ignore_lo", lo, 32'd6);
    chk("ignore_hi", hi, 32'd0);
    run("ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);
    tick();
    run("b2b1", OP_MULT, 32'd4, 32'd5, 5);
    chk("b2b1_lo", lo, 32'd20);
    run("b2b2", OP_MULT, 32'd6, 32'd7, 5);
    chk("b2b2_lo", lo, 32'd42);
    chk("b2b2_hi", hi, 32'd0);
    tick();
    issue(OP_DIV, 32'd100, 32'd7);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    chk("arst_done", done, 0);
    tick();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    chk("arst_no_commit", seen, 0);
    chk("arst_lo_after", lo, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mdu_unit.md
# mdu_unit

Parametrised multi-cycle multiply/divide unit with HI/LO registers, paired with the combinational ALU in the EX stage of the pipelined CPU. Accepts one operation per `start` pulse and holds `busy` for a configurable latency. Commits the 2×WIDTH result to HI/LO at the end of that latency. Supports flush-cancel of an in-flight operation for exception handling. The pipeline stalls any MDU-dependent instruction while `busy` or `start` is high.

## Interface
- `WIDTH`, default 32: operand width and HI/LO width.
- `MUL_LAT`, default 5: busy cycles for MULT/MULTU; must be ≥1.
- `DIV_LAT`, default 10: busy cycles for DIV/DIVU; must be ≥1.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: issue strobe; sampled on the rising edge.
- `op` input, 3 bits: operation code from `mdu_pkg`.
  - MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5.
  - Codes 6–7 are no-ops.
- `a` input, WIDTH bits: operand 1 (dividend / multiplicand).
- `b` input, WIDTH bits: operand 2.
- `cancel` input, 1 bit: flush; aborts any in-flight operation.
- `busy` output, 1 bit: high while a MULT/DIV operation is in flight.
- `done` output, 1 bit: one-cycle pulse in the cycle HI/LO take a new mult/div result.
- `hi` output, WIDTH bits: HI register.
- `lo` output, WIDTH bits: LO register.

## Operation
- States: IDLE and RUN.
- A down-counter `cnt` is sized `$clog2(max(MUL_LAT,DIV_LAT)+1)`.
- **IDLE, `start=1`, op ∈ {MULT, MULTU, DIV, DIVU}:**
  - Compute the result from `a`/`b` and store it in pending registers `p_hi`/`p_lo`.
  - Load `cnt` with the op latency and go to RUN.
- **IDLE, `start=1`, MTHI/MTLO:** write `a` to HI or LO at that edge. No busy, no `done`.
- **RUN:** `cnt` decrements each cycle. When `cnt==1`, at the next edge:
  - copy `p_hi`/`p_lo` to HI/LO,
  - pulse `done`,
  - return to IDLE.
- `start` in RUN is ignored, including MTHI/MTLO. The pipeline guarantees no issue while `busy`; the bench still checks the ignore.
- **`cancel=1`:** in RUN, go to IDLE, HI/LO unchanged, no `done`. In IDLE, any simultaneous `start` is dropped.
- **Arithmetic:**
  - MULT: signed 2W-bit product. HI = upper W bits, LO = lower W bits.
  - MULTU: same, unsigned.
  - DIV: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- **Boundary cases:**
  - `b==0` for DIV/DIVU: the full latency runs and `done` pulses, but HI/LO keep their old values.
  - DIV of most-negative by −1: LO = most-negative, HI = 0. No trap.
- **Reset (any time, including mid-RUN):**
  - state = IDLE, `cnt` = 0, `busy` = 0, `done` = 0,
  - `hi` = 0, `lo` = 0, `p_hi`/`p_lo` = 0.

## Timing
- `busy` is registered. It rises the cycle after the `start` edge and stays high for exactly MUL_LAT or DIV_LAT cycles.
- HI/LO change on the same edge that `busy` falls. `done` is high during the following cycle only.
- A new `start` is accepted in the first cycle `busy` is low, giving back-to-back throughput of LAT+1 cycles.
- MTHI/MTLO results are visible the cycle after `start`.
- `hi`/`lo` are direct register outputs, with no combinational path from inputs.
- **`cancel` and final-count edge coincide:** `cancel` wins. No commit, no `done`.

## Structure
- Package `mdu_pkg` holds:
  - the `op` encodings,
  - the state encoding (IDLE=0, RUN=1),
  - a `lat_of(op)` function returning MUL_LAT or DIV_LAT.
- Sub-module `mdu_calc` is purely combinational, parametrised by WIDTH: it takes `op`, `a`, `b` and returns `res_hi`, `res_lo`, `div0`.
- The top-level holds the FSM, counter, pending registers and HI/LO.

## Test plan
- **MULT:** reset, then MULT with a=−3 (0xFFFFFFFD), b=7 → `busy` high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, `done` high for 1 cycle.
- **DIV and DIVU:**
  - DIV a=−7, b=2 → after 10 cycles lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
  - DIVU a=7, b=2 → lo=3, hi=1.
- **Divide by zero:** MTHI 0x1234, MTLO 0x5678, then DIVU by 0 → `done` pulses, hi=0x1234, lo=0x5678 unchanged.
- **Cancel:**
  - MULTU 0xFFFFFFFF×2 with `cancel` asserted on the 3rd busy cycle → `busy` low next cycle, no `done`, HI/LO unchanged.
  - Repeat with `cancel` on the final-count edge → same result.
- **Busy handling and overflow:**
  - `start` MTLO while `busy` → ignored.
  - DIV 0x80000000 by 0xFFFFFFFF → lo=0x80000000, hi=0.
  - Back-to-back MULTs are accepted exactly LAT+1 cycles apart.
- **Reset mid-RUN:** pull `reset_n` low on busy cycle 2 of a DIV → busy=0, hi=lo=0, done=0 immediately (asynchronously), and no later commit after release.
